ex_muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU. It runs the M-extension ops over multiple cycles on a shared 33-bit add/subtract-shift datapath. While an op is in flight it holds the pipeline through stall_req, and it returns the result in the cycle the EX instruction advances. Forwarded operands reach it from the same EX operand muxes that feed the ALU.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/ex_muldiv_seq.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef logic [2:0] md_state_e;
  localparam md_state_e IDLE  = 3'd0;
  localparam md_state_e PREP  = 3'd1;
  localparam md_state_e CALC  = 3'd2;
  localparam md_state_e FIXUP = 3'd3;
  localparam md_state_e DONE  = 3'd4;

  function automatic logic is_div(md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed1(md_op_e op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed2(md_op_e op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration on the shared 33-bit adder: right-shift add for multiply,
// restoring trial-subtract with left shift for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);

  logic [XLEN:0] x, y, sum;
  logic          cin, cout;

  always_comb begin
    x    = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
    y    = is_div ? ~{1'b0, m} : (lo[0] ? {1'b0, m} : '0);
    cin  = is_div;
    {cout, sum} = {1'b0, x} + {1'b0, y} + {{(XLEN+1){1'b0}}, cin};
    hi_n = '0;
    lo_n = '0;
    if (is_div) begin
      // carry out means the partial remainder covered the divisor
      if (cout) begin
        hi_n = sum[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = x[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage RV32M sequencer: IDLE->PREP->CALC(x32)->FIXUP->DONE, stalling the pipe while busy.
// MULDIV_FUSE_EN keeps the last divide's operands/results so a matching DIV/REM completes in one cycle.
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state;
  md_op_e          op_r, op_in;
  logic [XLEN-1:0] op1_r, op2_r, hi, lo, m;
  logic [XLEN-1:0] step_hi, step_lo;
  logic            neg_q, neg_r;
  logic [CNT_W-1:0] cnt;

  logic            sa, sb, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, fin_q, fin_r, fin_div, mul_res;
  logic [2*XLEN-1:0] prod;
  logic            hit;
  logic [XLEN-1:0] hit_res;

  assign op_in = md_op_e'(op);

  always_comb begin
    sa      = is_signed1(op_r) & op1_r[XLEN-1];
    sb      = is_signed2(op_r) & op2_r[XLEN-1];
    a_mag   = sa ? -op1_r : op1_r;
    b_mag   = sb ? -op2_r : op2_r;
    div0    = is_div(op_r) && (op2_r == '0);
    ovf     = is_div(op_r) && is_signed1(op_r) && (op1_r == SMIN) && (op2_r == ONES);
    special = div0 | ovf;
    prod    = neg_q ? -{hi, lo} : {hi, lo};
    mul_res = (op_r == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    fin_q   = neg_q ? -lo : lo;
    fin_r   = neg_r ? -hi : hi;
    if (state == PREP && div0) begin
      fin_q = ONES;
      fin_r = op1_r;
    end else if (state == PREP && ovf) begin
      fin_q = SMIN;
      fin_r = '0;
    end
    fin_div = is_rem(op_r) ? fin_r : fin_q;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div(op_r)),
    .hi     (hi),
    .lo     (lo),
    .m      (m),
    .hi_n   (step_hi),
    .lo_n   (step_lo)
  );

`ifdef MULDIV_FUSE_EN
  logic            c_valid, c_sgn;
  logic [XLEN-1:0] c_op1, c_op2, c_q, c_r;

  assign hit     = c_valid && is_div(op_in) && (c_sgn == is_signed1(op_in)) &&
                   (c_op1 == op1) && (c_op2 == op2);
  assign hit_res = is_rem(op_in) ? c_r : c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_sgn   <= 1'b0;
      c_op1   <= '0;
      c_op2   <= '0;
      c_q     <= '0;
      c_r     <= '0;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (is_div(op_r) && ((state == PREP && special) || state == FIXUP)) begin
      c_valid <= 1'b1;
      c_sgn   <= is_signed1(op_r);
      c_op1   <= op1_r;
      c_op2   <= op2_r;
      c_q     <= fin_q;
      c_r     <= fin_r;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  assign stall_req = (state == IDLE && start) || state == PREP || state == CALC || state == FIXUP;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= MUL;
      op1_r  <= '0;
      op2_r  <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r  <= op_in;
          op1_r <= op1;
          op2_r <= op2;
          if (hit) begin
            result <= hit_res;
            state  <= DONE;
          end else begin
            state  <= PREP;
          end
        end
        PREP: begin
          // multiply walks the multiplier through lo; divide shifts the dividend out of lo
          neg_q <= sa ^ sb;
          neg_r <= sa;
          cnt   <= '0;
          hi    <= '0;
          lo    <= is_div(op_r) ? a_mag : b_mag;
          m     <= is_div(op_r) ? b_mag : a_mag;
          if (special) begin
            result <= fin_div;
            state  <= DONE;
          end else begin
            state  <= CALC;
          end
        end
        CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= FIXUP;
        end
        FIXUP: begin
          result <= is_div(op_r) ? fin_div : mul_res;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomized bench for ex_muldiv_seq against a plain-arithmetic RV32M model with latency expectations.
module tb_ex_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  // model of the last completed divide (only consulted when fusion is built in)
  bit          m_valid = 1'b0;
  bit          m_sgn = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;

  ex_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2]) begin
`ifdef MULDIV_FUSE_EN
      if (m_valid && m_a == a && m_b == b && m_sgn == !o[0]) return 1;
`endif
      if (b == 0) return 2;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    end
    return 35;
  endfunction

  // start asserted in the current cycle (T); done expected at T+lat
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r);
    int lat, got;
    logic bad;
    logic [31:0] exp;
    lat = exp_lat(o, a, b);
    exp = ref_md(o, a, b);
    start = 1'b1; op = o; op1 = a; op2 = b;
    #1;
    bad = (stall_req !== 1'b1);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
    got = 0;
    for (int k = 1; k <= 60 && got == 0; k++) begin
      if (done === 1'b1) begin
        got = k;
        if (stall_req !== 1'b0) bad = 1'b1;
      end else begin
        if (stall_req !== 1'b1 || busy !== 1'b1) bad = 1'b1;
        @(negedge clk);
      end
    end
    chk($sformatf("lat_op%0d_%h_%h", o, a, b), 32'(got), 32'(lat));
    chk($sformatf("res_op%0d_%h_%h", o, a, b), result, exp);
    chk($sformatf("stall_op%0d", o), {31'd0, bad}, 32'd0);
    if (o[2]) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_sgn = !o[0];
    end
    r = result;
    @(negedge clk);
    chk("idle_after", {30'd0, busy, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic        seen;

    repeat (3) @(negedge clk);
    chk("rst_outs", {29'd0, stall_req, busy, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, r);           chk("plan_mul", r, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);   chk("plan_mulhu", r, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);   chk("plan_mulh", r, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, r);   chk("plan_mulhsu", r, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, r);           chk("plan_div", r, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, r);           chk("plan_rem", r, 32'hFFFF_FFFF);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, r);           chk("plan_divu", r, 32'h7FFF_FFFC);
    run_op(3'd5, 32'd5, 32'd0, r);                   chk("plan_divu0", r, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, r);                   chk("plan_rem0", r, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r);   chk("plan_divovf", r, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r);   chk("plan_removf", r, 32'd0);

    // flush ten cycles into a divide, with a same-cycle start that must be ignored
    start = 1'b1; op = 3'd4; op1 = 32'd100; op2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1; start = 1'b1; op = 3'd0;
    if (done) seen = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    m_valid = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, seen | done}, 32'd0);
    run_op(3'd4, 32'd100, 32'd7, r);                 chk("plan_div_after_flush", r, 32'd14);
    run_op(3'd6, 32'd100, 32'd7, r);                 chk("plan_rem_pair", r, 32'd2);

    // reset between a divide and its matching remainder drops the stored entry
    run_op(3'd4, 32'd100, 32'd7, r);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    run_op(3'd6, 32'd100, 32'd7, r);                 chk("plan_rem_after_rst", r, 32'd2);

    // reset mid-op: aborted with no done pulse
    start = 1'b1; op = 3'd3; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    repeat (3) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_abort_done", {31'd0, seen}, 32'd0);
    chk("rst_abort_busy", {31'd0, busy}, 32'd0);
    chk("rst_abort_result", result, 32'd0);

    for (int i = 0; i < 50; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      // repeat the last divide's operands often enough to exercise fused completion
      if (m_valid && $urandom_range(0, 2) == 0) begin
        a = m_a; b = m_b;
        o = {1'b1, 1'($urandom_range(0, 1)), !m_sgn};
      end
      run_op(o, a, b, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
